// File: rtl/frame_buffer_pkg.sv
// Shared definitions for the double-buffered frame store: FSM encoding and bank selection.
package frame_buffer_pkg;

    localparam logic [1:0] ENC_FILL    = 2'd0;
    localparam logic [1:0] ENC_PENDING = 2'd1;
    localparam logic [1:0] ENC_SWAP    = 2'd2;

    typedef enum logic [1:0] {
        FILL    = ENC_FILL,
        PENDING = ENC_PENDING,
        SWAP    = ENC_SWAP
    } fb_state_t;

    // During SWAP the register still holds the old front bank, which is the new back bank.
    function automatic logic write_bank(input logic front_bank, input fb_state_t st);
        return (st == SWAP) ? front_bank : ~front_bank;
    endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// Simple dual-port word RAM holding both banks; one write port, one registered read port.
module frame_buffer_ram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW:0]   waddr,
    input  logic [15:0]   wdata,
    input  logic          re,
    input  logic [AW:0]   raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [0:(1 << (AW + 1)) - 1];

    // No reset here so the array and read register map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered pixel store: SPI writes fill the back bank, the scanner reads the front bank.
// Optional build macro FRAME_BUF_AUTOSWAP_EN swaps banks as soon as a frame lands, ignoring vsync.
module frame_buffer
    import frame_buffer_pkg::*;
#(
    parameter int ADDRESS_BUS_WIDTH = 12,
    parameter int FRAME_WORDS       = 4096,
    parameter int DROP_CNT_WIDTH    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [15:0]                  wr_data,
    input  logic [ADDRESS_BUS_WIDTH-1:0] wr_address,
    input  logic                         wr_strobe,
    input  logic                         vsync,
    input  logic                         rd_en,
    input  logic [ADDRESS_BUS_WIDTH-1:0] rd_addr,
    output logic [15:0]                  rd_data,
    output logic                         rd_valid,
    output logic                         front_bank,
    output logic                         frame_done,
    output logic                         swap_pending,
    output logic [DROP_CNT_WIDTH-1:0]    dropped_count,
    output logic [1:0]                   state_dbg
);

    localparam int AW = ADDRESS_BUS_WIDTH;
    localparam logic [AW:0]   FRAME_LIMIT = (AW + 1)'(FRAME_WORDS);
    localparam logic [AW-1:0] LAST_ADDR   = AW'(FRAME_WORDS - 1);

`ifdef FRAME_BUF_AUTOSWAP_EN
    localparam fb_state_t DONE_STATE = SWAP;
    localparam logic      DONE_PEND  = 1'b0;
    logic unused_vsync;
    assign unused_vsync = vsync;
`else
    localparam fb_state_t DONE_STATE = PENDING;
    localparam logic      DONE_PEND  = 1'b1;
`endif

    fb_state_t   state;
    logic        ever_read;
    logic [15:0] ram_q;
    logic        in_range;
    logic        accepting;
    logic        wr_en;
    logic        drop;
    logic        last_write;

    assign in_range   = {1'b0, wr_address} < FRAME_LIMIT;
    assign accepting  = (state == FILL) || (state == SWAP);
    assign wr_en      = wr_strobe && accepting && in_range;
    assign drop       = wr_strobe && !(accepting && in_range);
    assign last_write = wr_en && (wr_address == LAST_ADDR);
    assign state_dbg  = state;

    // Read register only updates on rd_en; gate it to zero until the first read after reset.
    assign rd_data = ever_read ? ram_q : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FILL;
            front_bank    <= 1'b0;
            frame_done    <= 1'b0;
            swap_pending  <= 1'b0;
            dropped_count <= '0;
            rd_valid      <= 1'b0;
            ever_read     <= 1'b0;
        end else begin
            rd_valid   <= rd_en;
            frame_done <= 1'b0;
            if (rd_en) begin
                ever_read <= 1'b1;
            end
            if (drop && !(&dropped_count)) begin
                dropped_count <= dropped_count + DROP_CNT_WIDTH'(1);
            end
            case (state)
                FILL: begin
                    if (last_write) begin
                        state        <= DONE_STATE;
                        swap_pending <= DONE_PEND;
                    end
                end
                PENDING: begin
`ifdef FRAME_BUF_AUTOSWAP_EN
                    state        <= FILL;
                    swap_pending <= 1'b0;
`else
                    if (vsync) begin
                        state        <= SWAP;
                        swap_pending <= 1'b0;
                    end
`endif
                end
                SWAP: begin
                    front_bank <= ~front_bank;
                    frame_done <= 1'b1;
                    if (last_write) begin
                        state        <= DONE_STATE;
                        swap_pending <= DONE_PEND;
                    end else begin
                        state <= FILL;
                    end
                end
                default: begin
                    state        <= FILL;
                    swap_pending <= 1'b0;
                end
            endcase
        end
    end

    frame_buffer_ram #(
        .AW(AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({write_bank(front_bank, state), wr_address}),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr ({front_bank, rd_addr}),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer: read vectors from a table plus hand-written swap/drop/reset sequences.
module tb_frame_buffer;
    import frame_buffer_pkg::*;

    localparam int AW  = 13;
    localparam int FW  = 4096;
    localparam int DCW = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [15:0]    wr_data = '0;
    logic [AW-1:0]  wr_address = '0;
    logic           wr_strobe = 1'b0;
    logic           vsync = 1'b0;
    logic           rd_en = 1'b0;
    logic [AW-1:0]  rd_addr = '0;
    logic [15:0]    rd_data;
    logic           rd_valid;
    logic           front_bank;
    logic           frame_done;
    logic           swap_pending;
    logic [DCW-1:0] dropped_count;
    logic [1:0]     state_dbg;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   exp;
    } rd_vec_t;
    rd_vec_t tbl[8];

    always #5 clk = ~clk;

    frame_buffer #(
        .ADDRESS_BUS_WIDTH(AW),
        .FRAME_WORDS      (FW),
        .DROP_CNT_WIDTH   (DCW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_data      (wr_data),
        .wr_address   (wr_address),
        .wr_strobe    (wr_strobe),
        .vsync        (vsync),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .front_bank   (front_bank),
        .frame_done   (frame_done),
        .swap_pending (swap_pending),
        .dropped_count(dropped_count),
        .state_dbg    (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the strobe released.
    task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
        wr_strobe  = 1'b1;
        wr_address = a;
        wr_data    = d;
        @(negedge clk);
        wr_strobe  = 1'b0;
    endtask

    task automatic fill_range(input int first, input int last, input logic [15:0] base);
        for (int i = first; i <= last; i++) begin
            wr(AW'(i), base + 16'(i));
        end
    endtask

    task automatic read_chk(input string name, input logic [AW-1:0] a, input logic [15:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_en   = 1'b0;
        check({name, ".valid"}, {31'b0, rd_valid}, 32'd1);
        check({name, ".data"}, {16'b0, rd_data}, {16'b0, exp});
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
    endtask

    initial begin
        int done_cnt;
        logic [15:0] pre_reset_exp;

        tbl[0] = '{addr: 13'd100,  exp: 16'd100};
        tbl[1] = '{addr: 13'd0,    exp: 16'd0};
        tbl[2] = '{addr: 13'd4095, exp: 16'd4095};
        tbl[3] = '{addr: 13'd2048, exp: 16'd2048};
        tbl[4] = '{addr: 13'd100,  exp: 16'h1064};
        tbl[5] = '{addr: 13'd0,    exp: 16'h1000};
        tbl[6] = '{addr: 13'd2047, exp: 16'h17FF};
        tbl[7] = '{addr: 13'd4095, exp: 16'h1FFF};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.state", {30'b0, state_dbg}, {30'b0, ENC_FILL});
        check("rst.front", {31'b0, front_bank}, 32'd0);
        check("rst.rd_data", {16'b0, rd_data}, 32'd0);
        check("rst.rd_valid", {31'b0, rd_valid}, 32'd0);
        check("rst.frame_done", {31'b0, frame_done}, 32'd0);
        check("rst.pending", {31'b0, swap_pending}, 32'd0);
        check("rst.dropped", {24'b0, dropped_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: full frame data=addr, then swap
        fill_range(0, FW - 1, 16'h0000);
        check("t1.front_before", {31'b0, front_bank}, 32'd0);
`ifdef FRAME_BUF_AUTOSWAP_EN
        check("t1.state_swap", {30'b0, state_dbg}, {30'b0, ENC_SWAP});
        check("t1.pending", {31'b0, swap_pending}, 32'd0);
        @(negedge clk);
`else
        check("t1.state_pend", {30'b0, state_dbg}, {30'b0, ENC_PENDING});
        check("t1.pending", {31'b0, swap_pending}, 32'd1);
        pulse_vsync();
        check("t1.state_swap", {30'b0, state_dbg}, {30'b0, ENC_SWAP});
        check("t1.front_in_swap", {31'b0, front_bank}, 32'd0);
        @(negedge clk);
`endif
        check("t1.front_after", {31'b0, front_bank}, 32'd1);
        check("t1.frame_done", {31'b0, frame_done}, 32'd1);
        check("t1.state_fill", {30'b0, state_dbg}, {30'b0, ENC_FILL});
        @(negedge clk);
        check("t1.frame_done_gone", {31'b0, frame_done}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            read_chk($sformatf("t1.rd%0d", i), tbl[i].addr, tbl[i].exp);
        end
        @(negedge clk);
        check("t1.valid_low", {31'b0, rd_valid}, 32'd0);
        check("t1.data_hold", {16'b0, rd_data}, 32'd2048);

        // Test 2: mid-fill reads see the previous frame; rd_valid lags rd_en by one cycle
        fill_range(0, FW / 2 - 1, 16'h1000);
        rd_en   = 1'b1;
        rd_addr = 13'd5;
        #1;
        check("t2.valid_lag", {31'b0, rd_valid}, 32'd0);
        @(negedge clk);
        rd_en = 1'b0;
        check("t2.valid", {31'b0, rd_valid}, 32'd1);
        check("t2.data5", {16'b0, rd_data}, 32'd5);
        read_chk("t2.rd100", 13'd100, 16'd100);
        check("t2.state_fill", {30'b0, state_dbg}, {30'b0, ENC_FILL});

`ifndef FRAME_BUF_AUTOSWAP_EN
        // Test 3: complete frame, 300 writes while pending saturate the drop counter
        fill_range(FW / 2, FW - 1, 16'h1000);
        for (int i = 0; i < 300; i++) begin
            wr(AW'(i), 16'hBEEF);
        end
        check("t3.pending", {31'b0, swap_pending}, 32'd1);
        check("t3.dropped", {24'b0, dropped_count}, 32'd255);
        check("t3.state", {30'b0, state_dbg}, {30'b0, ENC_PENDING});
        read_chk("t3.front_old", 13'd100, 16'd100);
        pulse_vsync();
        @(negedge clk);
        check("t3.front", {31'b0, front_bank}, 32'd0);
        check("t3.pending_clr", {31'b0, swap_pending}, 32'd0);
        for (int i = 4; i < 8; i++) begin
            read_chk($sformatf("t3.rd%0d", i), tbl[i].addr, tbl[i].exp);
        end

        // Test 4: final write coincides with vsync -> no swap until the next vsync
        fill_range(0, FW - 2, 16'h2000);
        wr_strobe  = 1'b1;
        wr_address = 13'd4095;
        wr_data    = 16'h2FFF;
        vsync      = 1'b1;
        @(negedge clk);
        wr_strobe  = 1'b0;
        vsync      = 1'b0;
        check("t4.state_pend", {30'b0, state_dbg}, {30'b0, ENC_PENDING});
        done_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (frame_done) done_cnt++;
        end
        check("t4.no_early_done", done_cnt, 32'd0);
        check("t4.front_held", {31'b0, front_bank}, 32'd0);
        pulse_vsync();
        repeat (4) begin
            @(negedge clk);
            if (frame_done) done_cnt++;
        end
        check("t4.done_once", done_cnt, 32'd1);
        check("t4.front", {31'b0, front_bank}, 32'd1);
        read_chk("t4.rd_last", 13'd4095, 16'h2FFF);
        read_chk("t4.rd_first", 13'd0, 16'h2000);
        pre_reset_exp = 16'h2000;
`else
        pre_reset_exp = 16'h0000;
`endif

        // Test 6: asynchronous reset in the middle of a fill
        rd_en   = 1'b1;
        rd_addr = 13'd0;
        fill_range(0, 9, 16'h3000);
        check("t6.pre_valid", {31'b0, rd_valid}, 32'd1);
        check("t6.pre_data", {16'b0, rd_data}, {16'b0, pre_reset_exp});
        #2 rst_n = 1'b0;
        #1;
        check("t6.front", {31'b0, front_bank}, 32'd0);
        check("t6.rd_valid", {31'b0, rd_valid}, 32'd0);
        check("t6.rd_data", {16'b0, rd_data}, 32'd0);
        check("t6.dropped", {24'b0, dropped_count}, 32'd0);
        check("t6.state", {30'b0, state_dbg}, {30'b0, ENC_FILL});
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 5: out-of-frame address is discarded and counted
        wr(13'd4096, 16'hDEAD);
        check("t5.dropped", {24'b0, dropped_count}, 32'd1);
        check("t5.state", {30'b0, state_dbg}, {30'b0, ENC_FILL});
        check("t5.pending", {31'b0, swap_pending}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
